ps2_receiver: RTL and testbench
===============================

Name: ps2_receiver

Overview:
Consumes the debounced PS/2 clock and data lines from the PS/2 debouncer and assembles 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop. Each valid scancode byte is delivered as a one-cycle strobe. E0 (extended) and F0 (release) prefix bytes are folded into flags on the following code byte. The block sits between the debouncer and the keyboard interface of the SoC.

Parameters:
TIMEOUT, 4000, clk cycles without a PS/2 falling edge before a partial frame is abandoned
CNT_W, 12, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset  input  1  synchronous, active-low reset
ps2Clk  input  1  debounced PS/2 clock line (idle high)
ps2Data  input  1  debounced PS/2 data line (idle high)
code  output  8  last accepted non-prefix scancode byte
codeValid  output  1  one-cycle strobe: code, extended and release are valid
extended  output  1  an E0 prefix preceded this code
release  output  1  an F0 prefix preceded this code
parityError  output  1  one-cycle strobe: frame dropped on parity
frameError  output  1  one-cycle strobe: frame dropped on bad start/stop or timeout

Behaviour:
- Input stage: two-flop synchroniser on both inputs, then a prevClk register. All three reset to 1, so reset never produces a spurious edge.
- fall = prevClk & ~clkSync. Every sample is taken from the synchronised data on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with bitCnt=0. On fall with data=1, stay in IDLE with no error.
  - DATA: on fall, shift data in at the MSB of an 8-bit shift register (shift right), so the first bit ends at bit 0. After the 8th bit (bitCnt==7), go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame and return to IDLE.
- Frame evaluation:
  - stop=0: frameError pulse.
  - Otherwise, XOR of the 8 data bits and the parity bit must be 1. If not: parityError pulse.
  - Both conditions bad: only frameError fires.
- Timeout:
  - Counter clears on every fall and while in IDLE; otherwise it increments and saturates.
  - In any non-IDLE state, reaching TIMEOUT-1 forces IDLE and a one-cycle frameError.
  - A fall in the same cycle as the timeout wins: the fall is processed and the counter clears.
- Accepted byte handling:
  - 0xE0: set extPending. No codeValid.
  - 0xF0: set relPending. No codeValid.
  - Any other value: code <= byte, extended <= extPending, release <= relPending, codeValid=1 for one cycle, then clear both pending flags.
  - Any error strobe also clears both pending flags.
- Output hold: code, extended and release hold their values until the next codeValid. Strobes are registered and high for exactly one clk cycle.
- Latency: codeValid/parityError/frameError go high after the 3rd rising clk edge following the stop-bit falling edge of ps2Clk (2 sync + 1 edge register). Timeout strobes go high after TIMEOUT-1 counted cycles.
- Mutual exclusion: codeValid, parityError and frameError are never high in the same cycle.
- Reset (reset=0 at a clk edge):
  - state=IDLE, bitCnt=0, shift=0, counter=0, pending flags=0.
  - code=0x00, all other outputs 0.
  - A frame in progress is aborted silently, with no error strobe.

Test Plan:
- Frame 0x1C (data 0,0,1,1,1,0,0,0, parity 0, stop 1), ps2Clk period 80 clk → exactly one codeValid, code=0x1C, extended=0, release=0, 3 cycles after the last fall; no error strobes.
- Frames E0, F0, 74 back-to-back → a single codeValid with code=0x74, extended=1, release=1. Next frame 0x1C → extended=0, release=0.
- Frame 0x1C with parity=1 → one parityError pulse, no codeValid, code stays at its previous value.
- Frame 0x1C with stop=0 → one frameError pulse, no codeValid. A following good 0x1C frame is accepted.
- Start bit plus 4 data bits, then ps2Clk held high → frameError exactly at counter TIMEOUT-1, state back in IDLE. A following 0x1C frame is accepted. Variant: prefix F0, then a timed-out frame, then 0x1C → release=0.
- Prefix E0 accepted, reset pulsed low mid-way through the next frame, then a full 0x1C frame → all outputs 0 during reset, no strobes during reset; after reset, codeValid with code=0x1C, extended=0.

Source files
------------

// File: rtl/ps2_receiver.sv
// Purpose: PS/2 device-to-host frame receiver; folds E0/F0 prefixes into flags on the next code byte.
// Latency: strobes rise 3 clk edges after the stop-bit ps2Clk fall (2 sync + 1 edge reg); timeout strobe TIMEOUT-1 cycles after the last fall.
// Backpressure: none; the PS/2 device cannot be stalled, so each strobe lasts one cycle and must be consumed.
module ps2_receiver #(
  parameter int TIMEOUT = 4000,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] code,
  output logic       codeValid,
  output logic       extended,
  output logic       released,
  output logic       parityError,
  output logic       frameError
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Compared against the registered count, so the strobe lands on the edge the count reaches TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk_meta, clk_sync, prev_clk;
  logic             data_meta, data_sync;
  logic             fall;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ext_pend, rel_pend;
  logic             frame_done, timeout;
  logic             frm_err, par_err, good, is_e0, is_f0;

  // Two-flop synchronisers plus edge register; reset high so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      prev_clk  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2Clk;
      clk_sync  <= clk_meta;
      prev_clk  <= clk_sync;
      data_meta <= ps2Data;
      data_sync <= data_meta;
    end
  end

  assign fall = prev_clk & ~clk_sync;

  // Next-state logic; a fall always takes priority over the timeout.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    timeout    = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE:    if (!data_sync) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == TO_LAST) begin
      state_d = IDLE;
      timeout = 1'b1;
    end
  end

  // A bad stop bit masks a parity failure so only one error strobe ever fires.
  assign frm_err = (frame_done & ~data_sync) | timeout;
  assign par_err = frame_done & data_sync & ~(^shift_q ^ parity_q);
  assign good    = frame_done & data_sync &  (^shift_q ^ parity_q);
  assign is_e0   = (shift_q == 8'hE0);
  assign is_f0   = (shift_q == 8'hF0);

  // State register, bit assembly and inter-edge timeout counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      bit_cnt  <= 3'd0;
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fall) begin
        case (state_q)
          IDLE:    bit_cnt <= 3'd0;
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            shift_q <= {data_sync, shift_q[7:1]};
          end
          PARITY:  parity_q <= data_sync;
          default: ;
        endcase
      end
      if (fall || state_q == IDLE || timeout) cnt_q <= '0;
      else if (cnt_q != CNT_MAX)               cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Prefix folding, held outputs and registered one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
      code        <= 8'h00;
      extended    <= 1'b0;
      released    <= 1'b0;
      codeValid   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
    end else begin
      codeValid   <= good & ~is_e0 & ~is_f0;
      parityError <= par_err;
      frameError  <= frm_err;
      if (frm_err || par_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (good) begin
        if (is_e0) begin
          ext_pend <= 1'b1;
        end else if (is_f0) begin
          rel_pend <= 1'b1;
        end else begin
          code     <= shift_q;
          extended <= ext_pend;
          released <= rel_pend;
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Purpose: self-checking bench for ps2_receiver: vector table, corner-case sequences, randomized frames vs a frame-level model.
// Latency: checks the 3-edge strobe latency and the TIMEOUT-1 timeout position exactly.
// Backpressure: not applicable; the bench drives PS/2 lines freely.
module tb_ps2_receiver;

  localparam int TIMEOUT = 200;
  localparam int CNT_W   = 8;
  localparam int HALF    = 40;

  localparam int K_NONE = 0;
  localparam int K_VAL  = 1;
  localparam int K_PAR  = 2;
  localparam int K_FRM  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] code;
  logic       codeValid, extended, released, parityError, frameError;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid = 0, n_par = 0, n_frm = 0;
  int valid_cyc = 0, frm_cyc = 0, last_fall_cyc = 0;

  // frame-level reference model state
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0, m_rel = 1'b0, p_ext = 1'b0, p_rel = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    int         kind;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_rel;
  } vec_t;

  vec_t vecs[15];

  ps2_receiver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .code(code), .codeValid(codeValid), .extended(extended), .released(released),
    .parityError(parityError), .frameError(frameError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // strobe monitor, sampled 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (codeValid === 1'b1)   begin n_valid++; valid_cyc = cyc; end
    if (parityError === 1'b1) n_par++;
    if (frameError === 1'b1)  begin n_frm++; frm_cyc = cyc; end
    if (codeValid || parityError || frameError)
      check("strobe_mutex", 32'(codeValid) + 32'(parityError) + 32'(frameError), 32'd1);
  end

  // odd-parity / stop / prefix rules applied to a whole frame
  task automatic model_frame(input logic [7:0] d, input logic bp, input logic bs, output int kind);
    if (bs || bp) begin
      kind  = bs ? K_FRM : K_PAR;
      p_ext = 1'b0;
      p_rel = 1'b0;
    end else if (d == 8'hE0) begin
      kind = K_NONE; p_ext = 1'b1;
    end else if (d == 8'hF0) begin
      kind = K_NONE; p_rel = 1'b1;
    end else begin
      kind   = K_VAL;
      m_code = d; m_ext = p_ext; m_rel = p_rel;
      p_ext  = 1'b0; p_rel = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b, input int half);
    ps2Data = b;
    repeat (half) @(negedge clk);
    ps2Clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (half) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bp, input logic bs, input int half);
    logic [10:0] f;
    f = {~bs, (~^d) ^ bp, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], half);
    ps2Data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits, input int half);
    ps2_bit(1'b0, half);
    for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), half);
    ps2Data = 1'b1;
    repeat (TIMEOUT + 20) @(negedge clk);
  endtask

  task automatic check_result(input string name, input int dv, input int dp, input int df,
                              input int kind, input logic [7:0] ec, input logic ee, input logic er);
    check({name, "_valid_cnt"}, 32'(dv), (kind == K_VAL) ? 32'd1 : 32'd0);
    check({name, "_par_cnt"},   32'(dp), (kind == K_PAR) ? 32'd1 : 32'd0);
    check({name, "_frm_cnt"},   32'(df), (kind == K_FRM) ? 32'd1 : 32'd0);
    check({name, "_code"},      32'(code), 32'(ec));
    check({name, "_ext"},       32'(extended), 32'(ee));
    check({name, "_rel"},       32'(released), 32'(er));
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic bp, input logic bs,
                           input int half, input int kind, input logic [7:0] ec, input logic ee, input logic er);
    int v0, p0, f0;
    v0 = n_valid; p0 = n_par; f0 = n_frm;
    send_frame(d, bp, bs, half);
    check_result(name, n_valid - v0, n_par - p0, n_frm - f0, kind, ec, ee, er);
  endtask

  task automatic run_model_frame(input string name, input logic [7:0] d, input logic bp, input logic bs, input int half);
    int kind;
    model_frame(d, bp, bs, kind);
    run_frame(name, d, bp, bs, half, kind, m_code, m_ext, m_rel);
  endtask

  task automatic run_timeout(input string name, input int nbits, input int half);
    int v0, p0, f0;
    v0 = n_valid; p0 = n_par; f0 = n_frm;
    p_ext = 1'b0; p_rel = 1'b0;
    send_partial(nbits, half);
    check_result(name, n_valid - v0, n_par - p0, n_frm - f0, K_FRM, m_code, m_ext, m_rel);
    check({name, "_to_pos"}, 32'(frm_cyc - last_fall_cyc), 32'(TIMEOUT + 2));
  endtask

  initial begin
    int kind, v0, p0, f0;
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, K_VAL,  8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, K_NONE, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, K_NONE, 8'h1C, 1'b0, 1'b0};
    vecs[3]  = '{8'h74, 1'b0, 1'b0, K_VAL,  8'h74, 1'b1, 1'b1};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, K_VAL,  8'h1C, 1'b0, 1'b0};
    vecs[5]  = '{8'h5A, 1'b0, 1'b0, K_VAL,  8'h5A, 1'b0, 1'b0};
    vecs[6]  = '{8'h1C, 1'b1, 1'b0, K_PAR,  8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{8'h1C, 1'b0, 1'b1, K_FRM,  8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{8'h1C, 1'b0, 1'b0, K_VAL,  8'h1C, 1'b0, 1'b0};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, K_NONE, 8'h1C, 1'b0, 1'b0};
    vecs[10] = '{8'h1C, 1'b1, 1'b0, K_PAR,  8'h1C, 1'b0, 1'b0};
    vecs[11] = '{8'h3B, 1'b0, 1'b0, K_VAL,  8'h3B, 1'b0, 1'b0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, K_NONE, 8'h3B, 1'b0, 1'b0};
    vecs[13] = '{8'h2B, 1'b1, 1'b1, K_FRM,  8'h3B, 1'b0, 1'b0};
    vecs[14] = '{8'h2B, 1'b0, 1'b0, K_VAL,  8'h2B, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    check("rst_code", 32'(code), 32'h0);
    check("rst_strobes", {29'd0, codeValid, parityError, frameError}, 32'd0);
    check("rst_flags", {30'd0, extended, released}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // first frame: exact strobe latency
    run_model_frame("first_1c", 8'h1C, 1'b0, 1'b0, HALF);
    check("first_latency", 32'(valid_cyc - last_fall_cyc), 32'd3);

    for (int i = 0; i < 15; i++) begin
      model_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, kind);
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, HALF,
                vecs[i].kind, vecs[i].exp_code, vecs[i].exp_ext, vecs[i].exp_rel);
    end

    // timeout after start + 4 data bits, then recovery
    run_timeout("timeout", 5, HALF);
    run_model_frame("after_to", 8'h1C, 1'b0, 1'b0, HALF);

    // F0 prefix lost to a timed-out frame
    run_model_frame("to_f0", 8'hF0, 1'b0, 1'b0, HALF);
    run_timeout("timeout_f0", 3, HALF);
    run_model_frame("after_to_f0", 8'h1C, 1'b0, 1'b0, HALF);
    check("after_to_f0_rel_exact", 32'(released), 32'd0);

    // reset in the middle of a frame following an E0 prefix
    run_model_frame("rst_e0", 8'hE0, 1'b0, 1'b0, HALF);
    ps2_bit(1'b0, HALF);
    ps2_bit(1'b0, HALF);
    ps2_bit(1'b1, HALF);
    v0 = n_valid; p0 = n_par; f0 = n_frm;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("in_rst_out", {20'd0, code, extended, released, codeValid, parityError}, 32'd0);
      check("in_rst_frm", 32'(frameError), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    m_code = 8'h00; m_ext = 1'b0; m_rel = 1'b0; p_ext = 1'b0; p_rel = 1'b0;
    repeat (TIMEOUT + 20) @(negedge clk);
    check("rst_no_strobes", 32'((n_valid - v0) + (n_par - p0) + (n_frm - f0)), 32'd0);
    run_model_frame("after_rst", 8'h1C, 1'b0, 1'b0, HALF);

    // randomized frames against the model
    for (int i = 0; i < 30; i++) begin
      int sel, half;
      logic [7:0] d;
      logic bp, bs;
      half = $urandom_range(10, 60);
      sel  = $urandom_range(0, 9);
      if (sel == 0) begin
        run_timeout($sformatf("rnd%0d_to", i), $urandom_range(1, 10), half);
      end else begin
        case ($urandom_range(0, 5))
          0:       d = 8'hE0;
          1:       d = 8'hF0;
          default: d = 8'($urandom_range(0, 255));
        endcase
        bp = ($urandom_range(0, 7) == 0);
        bs = ($urandom_range(0, 7) == 0);
        run_model_frame($sformatf("rnd%0d", i), d, bp, bs, half);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
